// File: rtl/router_pkt_tx.sv
// Generic synchronous FIFO; exposes the head entry and the entry behind it.
// Latency: a push is readable the next cycle; a pop advances the head the next cycle.
// Backpressure: pushes when full and pops when empty are dropped; the caller gates them.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       rd_rdy,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [WIDTH-1:0]           rd_nxt_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign push       = wr_vld && (count != CW'(DEPTH));
    assign pop        = rd_rdy && (count != '0);
    assign rd_dat     = mem[rd_ptr];
    assign rd_nxt_dat = mem[ptr_inc(rd_ptr)];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end
endmodule

// Packet transmitter: buffers up to 7 payload beats, sends header, length, payload, parity.
// Latency: header one cycle after an accepted start; one beat per unstalled cycle thereafter.
// Backpressure: busy freezes the presented beat and the FSM; writes/start only accepted when ready.
module router_pkt_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_data,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic       busy,
    output logic [2:0] data_out,
    output logic       packet_valid,
    output logic       ready,
    output logic [2:0] buf_count,
    output logic       tx_done,
    output logic       cfg_err,
    output logic       wr_ovf
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
    localparam logic [2:0] S_PAR  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] BUF_FULL = 3'd7;

    logic [2:0] state;
    logic [2:0] len_q;
    logic [2:0] parity_q;
    logic [2:0] head_dat;
    logic [2:0] nxt_dat;
    logic       push_vld;
    logic       pop_rdy;
    logic       start_ok;
    logic       start_bad;
    logic       wr_drop;

    // start takes precedence over a write in the same IDLE cycle, even when rejected
    assign ready     = (state == S_IDLE);
    assign push_vld  = ready && wr_en && !start && (buf_count != BUF_FULL);
    assign wr_drop   = ready && wr_en && !start && (buf_count == BUF_FULL);
    assign start_ok  = ready && start && (dest != 2'd3) && (buf_count != 3'd0);
    assign start_bad = ready && start && !start_ok;
    assign pop_rdy   = (state == S_PAY) && !busy;

    fifo #(.WIDTH(3), .DEPTH(7)) u_pay_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_vld     (push_vld),
        .wr_dat     (wr_data),
        .rd_rdy     (pop_rdy),
        .rd_dat     (head_dat),
        .rd_nxt_dat (nxt_dat),
        .count      (buf_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            data_out     <= 3'd0;
            packet_valid <= 1'b0;
            len_q        <= 3'd0;
            parity_q     <= 3'd0;
            tx_done      <= 1'b0;
            cfg_err      <= 1'b0;
            wr_ovf       <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            cfg_err <= start_bad;
            wr_ovf  <= wr_drop;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state        <= S_HDR;
                        data_out     <= {1'b0, dest};
                        packet_valid <= 1'b1;
                        len_q        <= buf_count;
                        parity_q     <= 3'd0;
                    end
                end
                S_HDR: begin
                    if (!busy) begin
                        state    <= S_LEN;
                        data_out <= len_q;
                        parity_q <= parity_q ^ data_out;
                    end
                end
                S_LEN: begin
                    if (!busy) begin
                        state    <= S_PAY;
                        data_out <= head_dat;
                        parity_q <= parity_q ^ data_out;
                    end
                end
                S_PAY: begin
                    // the head is popped as it is consumed; prefetch the entry behind it
                    if (!busy) begin
                        parity_q <= parity_q ^ data_out;
                        if (buf_count == 3'd1) begin
                            state        <= S_PAR;
                            data_out     <= parity_q ^ data_out;
                            packet_valid <= 1'b0;
                        end else begin
                            data_out <= nxt_dat;
                        end
                    end
                end
                S_PAR: begin
                    if (!busy) begin
                        state    <= S_DONE;
                        data_out <= 3'd0;
                        tx_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state        <= S_IDLE;
                    data_out     <= 3'd0;
                    packet_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomised bench for router_pkt_tx: a queue model predicts every beat, a negedge monitor checks them.
module tb_router_pkt_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_data;
    logic       start;
    logic [1:0] dest;
    logic       busy;
    logic [2:0] data_out;
    logic       packet_valid;
    logic       ready;
    logic [2:0] buf_count;
    logic       tx_done;
    logic       cfg_err;
    logic       wr_ovf;

    router_pkt_tx dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .start        (start),
        .dest         (dest),
        .busy         (busy),
        .data_out     (data_out),
        .packet_valid (packet_valid),
        .ready        (ready),
        .buf_count    (buf_count),
        .tx_done      (tx_done),
        .cfg_err      (cfg_err),
        .wr_ovf       (wr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] dat;
        logic       vld;
    } beat_t;

    beat_t      sb_q[$];
    logic [2:0] model_buf[$];
    int n_checks = 0, n_pass = 0;
    int exp_done = 0, exp_cfg = 0, exp_ovf = 0;
    int n_done = 0, n_cfg = 0, n_ovf = 0;
    bit         done_pend = 1'b0;
    bit         hold_chk = 1'b0;
    logic [2:0] hold_dat;
    logic       hold_vld;
    beat_t      mon_e;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Monitor: a beat is consumed when presented (not IDLE, not DONE) with busy low
    always @(negedge clk) begin
        if (rst) begin
            done_pend = 1'b0;
            hold_chk  = 1'b0;
        end else begin
            if (done_pend) begin
                chk("tx_done after parity", int'(tx_done), 1);
                chk("data_out in done", int'(data_out), 0);
                done_pend = 1'b0;
            end else if (tx_done) begin
                chk("tx_done spurious", int'(tx_done), 0);
            end
            if (hold_chk) begin
                chk("stall hold data", int'(data_out), int'(hold_dat));
                chk("stall hold valid", int'(packet_valid), int'(hold_vld));
            end
            hold_chk = 1'b0;
            if (!ready && !tx_done) begin
                if (busy) begin
                    hold_chk = 1'b1;
                    hold_dat = data_out;
                    hold_vld = packet_valid;
                end else if (sb_q.size() == 0) begin
                    chk("unexpected beat", sb_q.size(), 1);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("beat data", int'(data_out), int'(mon_e.dat));
                    chk("beat valid", int'(packet_valid), int'(mon_e.vld));
                    if (!mon_e.vld) done_pend = 1'b1;
                end
            end
            if (cfg_err) n_cfg++;
            if (wr_ovf)  n_ovf++;
            if (tx_done) n_done++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input logic [2:0] v);
        int full;
        full    = (model_buf.size() >= 7) ? 1 : 0;
        wr_en   = 1'b1;
        wr_data = v;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (full == 0) model_buf.push_back(v);
        else exp_ovf++;
        chk("wr_ovf pulse", int'(wr_ovf), full);
        chk("buf_count after write", int'(buf_count), model_buf.size());
    endtask

    // mode 0: no stall, 1: random busy and write noise, 2: 3-cycle stall on 2nd payload beat,
    // 3: reset while the 2nd payload beat (or parity of a 1-beat packet) is presented
    task automatic do_start(input logic [1:0] d, input int mode, input bit also_wr);
        int         n, k, stalls, beat, stall_left;
        bit         ok, b, presented;
        logic [2:0] par;
        beat_t      e;
        n  = model_buf.size();
        ok = (d != 2'd3) && (n != 0);
        start = 1'b1;
        dest  = d;
        if (also_wr) begin
            wr_en   = 1'b1;
            wr_data = 3'($urandom);
        end
        if (ok) begin
            par = {1'b0, d} ^ 3'(n);
            e.vld = 1'b1;
            e.dat = {1'b0, d};
            sb_q.push_back(e);
            e.dat = 3'(n);
            sb_q.push_back(e);
            foreach (model_buf[i]) begin
                e.dat = model_buf[i];
                sb_q.push_back(e);
                par ^= model_buf[i];
            end
            e.dat = par;
            e.vld = 1'b0;
            sb_q.push_back(e);
            model_buf.delete();
            exp_done++;
        end else begin
            exp_cfg++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        if (!ok) begin
            chk("cfg_err pulse", int'(cfg_err), 1);
            chk("ready after reject", int'(ready), 1);
            chk("buf_count after reject", int'(buf_count), n);
            return;
        end
        chk("ready drops after start", int'(ready), 0);
        k = 1;
        stalls = 0;
        beat = 0;
        stall_left = 3;
        while (!ready && k < 200) begin
            presented = !tx_done;
            b = 1'b0;
            if (mode == 3 && presented && beat == 3) begin
                busy  = 1'b0;
                wr_en = 1'b0;
                rst   = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk("abort data_out", int'(data_out), 0);
                chk("abort packet_valid", int'(packet_valid), 0);
                chk("abort ready", int'(ready), 1);
                chk("abort buf_count", int'(buf_count), 0);
                chk("abort tx_done", int'(tx_done), 0);
                sb_q.delete();
                exp_done--;
                return;
            end
            if (mode == 1) begin
                b       = ($urandom_range(0, 3) == 0);
                wr_en   = 1'($urandom_range(0, 1));
                wr_data = 3'($urandom);
            end else if (mode == 2 && presented && beat == 3 && stall_left > 0) begin
                b = 1'b1;
                stall_left--;
            end
            busy = b;
            if (presented && b)  stalls++;
            if (presented && !b) beat++;
            @(posedge clk);
            #1;
            k++;
        end
        busy  = 1'b0;
        wr_en = 1'b0;
        if (ready) chk("start-to-ready cycles", k, n + 5 + stalls);
        else       chk("packet completes", int'(ready), 1);
        chk("buf_count after packet", int'(buf_count), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 3'd0; start = 1'b0; dest = 2'd0; busy = 1'b0;
        idle(2);
        chk("reset ready", int'(ready), 1);
        chk("reset buf_count", int'(buf_count), 0);
        chk("reset data_out", int'(data_out), 0);
        chk("reset packet_valid", int'(packet_valid), 0);
        chk("reset tx_done", int'(tx_done), 0);
        chk("reset cfg_err", int'(cfg_err), 0);
        chk("reset wr_ovf", int'(wr_ovf), 0);
        rst = 1'b0;
        idle(1);

        do_write(3'd5); do_write(3'd2); do_write(3'd7);
        do_start(2'd1, 0, 1'b0);
        idle(1);
        do_write(3'd5); do_write(3'd2); do_write(3'd7);
        do_start(2'd1, 2, 1'b0);
        idle(1);
        for (int i = 0; i < 8; i++) do_write(3'd4);
        do_start(2'd0, 0, 1'b0);
        idle(1);
        do_start(2'd0, 0, 1'b0);
        do_write(3'd5);
        do_start(2'd3, 0, 1'b0);
        do_write(3'd1); do_write(3'd3);
        do_start(2'd2, 3, 1'b0);
        do_write(3'd6);
        do_start(2'd2, 0, 1'b0);
        idle(1);
        do_write(3'd3);
        do_start(2'd1, 0, 1'b1);
        idle(1);

        for (int it = 0; it < 40; it++) begin
            int         nw, md;
            logic [1:0] d;
            bit         aw;
            nw = $urandom_range(0, 9);
            for (int j = 0; j < nw; j++) do_write(3'($urandom));
            d  = 2'($urandom_range(0, 3));
            md = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) md = 3;
            aw = 1'($urandom_range(0, 1));
            do_start(d, md, aw);
            idle($urandom_range(0, 2));
        end

        idle(3);
        chk("tx_done count", n_done, exp_done);
        chk("cfg_err count", n_cfg, exp_cfg);
        chk("wr_ovf count", n_ovf, exp_ovf);
        chk("scoreboard drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
